// File: rtl/data_unpacker_stream_pkg.sv
// Shared helpers for the streaming unpacker: lane-count math, count saturation
// and the lane-order encodings.
package data_unpacker_stream_pkg;

  localparam bit LSB_FIRST_ORDER = 1'b1;
  localparam bit MSB_FIRST_ORDER = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Lanes per packed word; a partial top lane still counts as a lane.
  function automatic int lanes_of(input int in_w, input int out_w);
    int l;
    l = (in_w + out_w - 1) / out_w;
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int sat_count(input int cnt, input int lanes);
    return (cnt > lanes) ? lanes : cnt;
  endfunction

endpackage

// File: rtl/data_unpacker_stream_lane_shift_reg.sv
// Current-word register: parallel load with lane count, then shifts one lane
// out per accepted transfer. Load wins over shift.
module data_unpacker_stream_lane_shift_reg #(
  parameter int OUT_WIDTH = 64,
  parameter int LANES     = 2,
  parameter int CNT_W     = 2,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [LANES*OUT_WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0]           load_cnt,
  input  logic                       shift,
  output logic [OUT_WIDTH-1:0]       lane,
  output logic [CNT_W-1:0]           cnt
);

  localparam int CUR_W = LANES * OUT_WIDTH;

  logic [CUR_W-1:0] cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      cnt <= '0;
    end else if (load) begin
      cur <= load_data;
      cnt <= load_cnt;
    end else if (shift) begin
      cur <= LSB_FIRST ? (cur >> OUT_WIDTH) : (cur << OUT_WIDTH);
      cnt <= cnt - 1'b1;
    end
  end

  assign lane = LSB_FIRST ? cur[OUT_WIDTH-1:0] : cur[CUR_W-1 -: OUT_WIDTH];

endmodule

// File: rtl/data_unpacker_stream.sv
// Backpressure-aware packed-word unpacker: a cur shift register plus one
// pending slot, so words stream back-to-back with no idle lane cycles.
module data_unpacker_stream
  import data_unpacker_stream_pkg::*;
#(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 64,
  parameter bit LSB_FIRST = LSB_FIRST_ORDER,
  localparam int LANES    = lanes_of(IN_WIDTH, OUT_WIDTH),
  localparam int CNT_W    = clog2(LANES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m_packed_read_ready,
  output logic                 m_packed_read_req,
  input  logic [IN_WIDTH-1:0]  m_packed_read_data,
  input  logic [CNT_W-1:0]     m_packed_read_count,
  input  logic                 m_unpacked_write_ready,
  output logic                 m_unpacked_write_req,
  output logic [OUT_WIDTH-1:0] m_unpacked_write_data,
  output logic                 m_unpacked_write_last,
  output logic                 busy
);

  localparam int CUR_W = LANES * OUT_WIDTH;

  logic [CUR_W-1:0] ret_word, nxt_word, load_word;
  logic [CNT_W-1:0] ret_cnt, nxt_cnt, load_cnt, cur_cnt;
  logic             nxt_vld, inflight, ret_ok, xfer, cur_free, load, store_nxt;
  logic [1:0]       slots_used;

  // Zero-extension pads the top lane when IN_WIDTH is not a lane multiple.
  assign ret_word = CUR_W'(m_packed_read_data);
  assign ret_cnt  = CNT_W'(sat_count(int'(m_packed_read_count), LANES));
  assign ret_ok   = inflight && (ret_cnt != '0);

  assign xfer     = m_unpacked_write_req && m_unpacked_write_ready;
  assign cur_free = (cur_cnt == '0) || (xfer && (cur_cnt == CNT_W'(1)));

  // Pending slot has priority for cur; a return goes to nxt if cur stays busy
  // or nxt is itself moving into cur this cycle.
  assign load      = cur_free && (nxt_vld || ret_ok);
  assign load_word = nxt_vld ? nxt_word : ret_word;
  assign load_cnt  = nxt_vld ? nxt_cnt  : ret_cnt;
  assign store_nxt = ret_ok && (!cur_free || nxt_vld);

  assign slots_used        = 2'(cur_cnt != '0) + 2'(nxt_vld) + 2'(inflight);
  assign m_packed_read_req = m_packed_read_ready && !reset && (slots_used < 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      nxt_vld  <= 1'b0;
      nxt_word <= '0;
      nxt_cnt  <= '0;
    end else begin
      inflight <= m_packed_read_req;
      nxt_vld  <= store_nxt || (nxt_vld && !cur_free);
      if (store_nxt) begin
        nxt_word <= ret_word;
        nxt_cnt  <= ret_cnt;
      end
    end
  end

  data_unpacker_stream_lane_shift_reg #(
    .OUT_WIDTH (OUT_WIDTH),
    .LANES     (LANES),
    .CNT_W     (CNT_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_cur (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_word),
    .load_cnt  (load_cnt),
    .shift     (xfer),
    .lane      (m_unpacked_write_data),
    .cnt       (cur_cnt)
  );

  assign m_unpacked_write_req  = (cur_cnt != '0);
  assign m_unpacked_write_last = m_unpacked_write_req && (cur_cnt == CNT_W'(1));
  assign busy                  = inflight || (cur_cnt != '0) || nxt_vld;

endmodule
